// File: rtl/key_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// key_conditioner_pkg
//
// Shared definitions for the front-button conditioner of the fryer
// controller: the hold-state encoding used by every channel, the default
// parameter values of the block, and a small helper that sizes the hold
// counter.
//
// Contents:
//   hold_state_t      RELEASED=0, HELD=1, REPEAT=2 (2 bits)
//   DEF_*             default parameter values for key_conditioner
//   max_of()          larger of two integers
//   hold_cnt_width()  width of the per-channel hold tick counter
// ---------------------------------------------------------------------------
package key_conditioner_pkg;

    localparam int DEF_N_KEYS       = 8;
    localparam int DEF_CNT_NUM      = 4;
    localparam int DEF_T_TICK       = 50000;
    localparam int DEF_REPEAT_DELAY = 50;
    localparam int DEF_REPEAT_RATE  = 10;

    // Hold tracking of one key: idle, pressed but not yet repeating, and
    // repeating. The encoding is fixed so it can be observed on a debug bus.
    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HELD     = 2'd1,
        REPEAT   = 2'd2
    } hold_state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The hold counter has to reach the larger of the two tick intervals
    // minus one, so one spare code keeps it wide enough for both.
    function automatic int hold_cnt_width(input int delay, input int rate);
        return $clog2(max_of(delay, rate) + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// ---------------------------------------------------------------------------
// key_channel
//
// One button channel: two-flop synchroniser, counting debouncer, hold /
// auto-repeat state machine and the enable gating of the event pulses.
//
// Parameters:
//   CNT_NUM       synchronised samples that must disagree before a flip
//   REPEAT_DELAY  ticks held before the first repeat
//   REPEAT_RATE   ticks between later repeats
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   key_raw      in   asynchronous button level, 1 = pressed
//   key_en       in   pulses allowed when 1
//   tick         in   one-cycle hold tick from the shared prescaler
//   key_level    out  debounced level (never masked)
//   key_press    out  one-cycle pulse on debounced rise, gated
//   key_release  out  one-cycle pulse on debounced fall, gated
//   key_act      out  one-cycle pulse on press and on each repeat, gated
//   key_long     out  high while repeating (never masked)
// ---------------------------------------------------------------------------
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter int CNT_NUM      = DEF_CNT_NUM,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    input  logic key_en,
    input  logic tick,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_act,
    output logic key_long
);

    localparam int CNT_W  = $clog2(CNT_NUM);
    localparam int HOLD_W = hold_cnt_width(REPEAT_DELAY, REPEAT_RATE);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CNT_NUM - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

    logic              sync_1;
    logic              sync_2;
    logic [CNT_W-1:0]  deb_cnt;

    hold_state_t       hold_state;
    logic [HOLD_W-1:0] hold_cnt;

    logic deb_flip;
    logic deb_rise;
    logic deb_fall;
    logic hold_hit;
    logic repeat_ev;

    // Event decode for this cycle. A flip happens on the CNT_NUM-th
    // consecutive disagreeing sample, so the rise/fall events line up with
    // the edge on which key_level itself changes. A repeat that lands on
    // the same cycle as a debounced fall is suppressed: the key is already
    // gone by the time the repeat would be seen.
    always_comb begin
        deb_flip = (sync_2 != key_level) && (deb_cnt == CNT_LAST);
        deb_rise = deb_flip && sync_2;
        deb_fall = deb_flip && !sync_2;
        hold_hit = 1'b0;
        case (hold_state)
            HELD:    hold_hit = tick && (hold_cnt == DELAY_LAST);
            REPEAT:  hold_hit = tick && (hold_cnt == RATE_LAST);
            default: hold_hit = 1'b0;
        endcase
        repeat_ev = hold_hit && !deb_fall;
    end

    // Synchroniser and debouncer. The raw pin passes two flops before it is
    // trusted; the counter then runs only while the synchronised sample
    // disagrees with the stable level, and any agreeing sample throws the
    // partial count away so short bounces never reach key_level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            key_level <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
            if (sync_2 == key_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
                key_level <= sync_2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    // Hold state machine with registered, enable-gated pulses. Ticks are
    // only counted once the key is in HELD, so a tick in the very cycle of
    // the debounced rise does not shorten the first repeat delay. The
    // enable is applied at the moment the event happens; a masked event is
    // simply lost, while the hold tracking carries on regardless so that
    // re-enabling mid-hold picks up the repeat cadence already running.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_state  <= RELEASED;
            hold_cnt    <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_act     <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= deb_rise && key_en;
            key_release <= deb_fall && key_en;
            key_act     <= (deb_rise || repeat_ev) && key_en;
            case (hold_state)
                RELEASED: begin
                    if (deb_rise) begin
                        hold_state <= HELD;
                        hold_cnt   <= '0;
                    end
                end
                HELD: begin
                    if (deb_fall) begin
                        hold_state <= RELEASED;
                        hold_cnt   <= '0;
                        key_long   <= 1'b0;
                    end else if (tick) begin
                        if (hold_cnt == DELAY_LAST) begin
                            hold_state <= REPEAT;
                            hold_cnt   <= '0;
                            key_long   <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (deb_fall) begin
                        hold_state <= RELEASED;
                        hold_cnt   <= '0;
                        key_long   <= 1'b0;
                    end else if (tick) begin
                        if (hold_cnt == RATE_LAST) begin
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    hold_state <= RELEASED;
                    hold_cnt   <= '0;
                    key_long   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//
// Multi-channel front-button conditioner sitting between the board button
// pins and the fryer mode/time FSM. Each channel is synchronised and
// debounced, produces press/release/activity pulses, supports hold
// auto-repeat and can be masked per channel.
//
// Parameters:
//   N_KEYS        number of channels
//   CNT_NUM       debounce sample count (>= 2)
//   T_TICK        clk cycles per hold tick (>= 2)
//   REPEAT_DELAY  ticks before the first repeat (>= 1)
//   REPEAT_RATE   ticks between later repeats (>= 1)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   key_raw      in   [N_KEYS] asynchronous button levels, 1 = pressed
//   key_en       in   [N_KEYS] per-channel pulse enable
//   key_level    out  [N_KEYS] debounced levels (not masked)
//   key_press    out  [N_KEYS] press pulses, gated by key_en
//   key_release  out  [N_KEYS] release pulses, gated by key_en
//   key_act      out  [N_KEYS] press and repeat pulses, gated by key_en
//   key_long     out  [N_KEYS] high from first repeat until release
// ---------------------------------------------------------------------------
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS       = DEF_N_KEYS,
    parameter int CNT_NUM      = DEF_CNT_NUM,
    parameter int T_TICK       = DEF_T_TICK,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_KEYS-1:0] key_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_act,
    output logic [N_KEYS-1:0] key_long
);

    localparam int PRE_W = $clog2(T_TICK);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(T_TICK - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    // Shared hold-tick prescaler. One counter serves every channel, so all
    // channels see the same tick phase; a key's first repeat therefore
    // carries up to one tick period of jitter depending on when it was
    // pressed relative to this counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    // One independent conditioner per button.
    generate
        for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
            key_channel #(
                .CNT_NUM      (CNT_NUM),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_RATE  (REPEAT_RATE)
            ) u_channel (
                .clk         (clk),
                .rst         (rst),
                .key_raw     (key_raw[g]),
                .key_en      (key_en[g]),
                .tick        (tick),
                .key_level   (key_level[g]),
                .key_press   (key_press[g]),
                .key_release (key_release[g]),
                .key_act     (key_act[g]),
                .key_long    (key_long[g])
            );
        end
    endgenerate

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised multi-channel front-button conditioner for the fryer controller. It replaces the per-button debounce instances with one block. For each channel it synchronises and debounces the raw button level, then emits one-cycle press and release pulses. It also adds tick-based hold auto-repeat, so holding the time-set buttons steps the digits, and a per-channel enable mask, so the FSM can ignore keys while heating. It sits between the board button pins and the fryer mode/time FSM.

## Interface
- N_KEYS, 8, number of channels
- CNT_NUM, 4, consecutive synchronised samples that must disagree with the stable level before it flips (≥2)
- T_TICK, 50000, clk cycles per hold tick (≥2)
- REPEAT_DELAY, 50, ticks a key is held before the first repeat (≥1)
- REPEAT_RATE, 10, ticks between later repeats (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_raw  in  N_KEYS  asynchronous button levels, 1 = pressed
- key_en  in  N_KEYS  per-channel enable, 1 = pulses allowed
- key_level  out  N_KEYS  debounced level (not masked)
- key_press  out  N_KEYS  one-cycle pulse on debounced 0→1, gated by key_en
- key_release  out  N_KEYS  one-cycle pulse on debounced 1→0, gated by key_en
- key_act  out  N_KEYS  one-cycle pulse on each press and each auto-repeat, gated by key_en
- key_long  out  N_KEYS  level, high from first repeat until release (not masked)

## Operation
- Synchroniser: two flops per channel, s1 then s2.
- Debounce, per channel:
  - cnt is $clog2(CNT_NUM) bits.
  - When s2 ≠ key_level, cnt increments.
  - When s2 ≠ key_level and cnt == CNT_NUM-1: key_level ← s2 and cnt ← 0.
  - When s2 == key_level: cnt ← 0, so any glitch restarts the count.
- Prescaler:
  - A single shared counter runs 0..T_TICK-1.
  - tick is high for one cycle when the counter is T_TICK-1.
  - The counter is 0 on the first cycle after rst.
- Per-channel hold FSM:
  - RELEASED: on the debounced rise go to HELD with hcnt ← 0.
  - HELD: each tick increments hcnt. On the tick where hcnt+1 == REPEAT_DELAY, emit a repeat, set hcnt ← 0 and go to REPEAT.
  - REPEAT: each tick increments hcnt. On the tick where hcnt+1 == REPEAT_RATE, emit a repeat and set hcnt ← 0.
  - In HELD or REPEAT, a debounced fall returns the FSM to RELEASED immediately, even on a tick cycle.
- hcnt width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
- key_long = (state == REPEAT).
- Output gating:
  - key_press, key_release and key_act are registered and ANDed with key_en as sampled in the cycle the event occurs.
  - An event that is masked is dropped, not deferred.
  - Debounce and hold tracking continue while a channel is masked.
- Channels are fully independent. Simultaneous events on several channels produce pulses in the same cycle.

## Timing
- Reset: every output is 0, and every internal register is 0 or RELEASED.
  - Reset mid-operation aborts any hold or repeat with no release pulse.
  - A key still held through reset is seen as a new press 2+CNT_NUM cycles after rst falls.
- Latency: if key_raw changes before edge k and then stays stable, key_level changes at edge k+1+CNT_NUM.
  - Of that, 2 edges are the synchroniser and CNT_NUM edges are the debounce.
  - key_press/key_release and the first key_act are high during the first cycle of the new key_level.
- A bounce shorter than CNT_NUM synchronised cycles never changes key_level.
- First repeat: on the REPEAT_DELAY-th tick edge strictly after the press cycle.
  - This is 1..T_TICK cycles of phase jitter plus (REPEAT_DELAY-1)·T_TICK.
  - Later repeats are exactly REPEAT_RATE·T_TICK cycles apart.
- key_act pulses from a press and from a repeat can never coincide. A repeat requires at least one tick in HELD.
- A release on a tick cycle produces no repeat.

## Structure
- A shared package holds the hold-state encoding (RELEASED=0, HELD=1, REPEAT=2, 2 bits) and the default parameter values.
- One sub-module, key_channel, contains the synchroniser, debounce, hold FSM and gating, and is instantiated N_KEYS times with a generate loop.
- The prescaler lives in the top level and drives tick to all channels.

## Test plan
All scenarios use CNT_NUM=4, T_TICK=10, REPEAT_DELAY=5, REPEAT_RATE=2, N_KEYS=8 and key_en all ones unless stated.
- Clean press: key_raw[6] rises before edge 100 and stays high → key_level[6], key_press[6] and key_act[6] rise at edge 105, and both pulses last 1 cycle. On release → key_release[6] pulses 1 cycle, 6 edges after the raw fall.
- Bounce: key_raw[7] toggles with high times of 1, 2, 3 cycles, then holds high → no press until 4 stable synchronised cycles have elapsed, then exactly one key_press.
- Auto-repeat: key 6 held for 200 cycles → key_act pulses once at press, then at the 5th tick after press, then every 20 cycles. key_long is high from the first repeat until release.
- Mask: key_en[6]=0 while key 6 is pressed and held → key_level[6] follows the key, and key_press, key_act and key_release[6] stay 0. Setting key_en[6]=1 mid-hold → later repeats appear and the missed press is not replayed.
- Simultaneous events: keys 0, 3 and 7 rise in the same cycle → their key_press bits assert in the same cycle, and the other bits stay 0.
- Reset mid-repeat: rst is pulsed for 1 cycle while key 6 is repeating and held → all outputs are 0 the next cycle, and key_press[6] reappears 6 cycles after rst falls.
